// File: rtl/ras.sv
// Return address stack: circular entry buffer with a wrapping top-of-stack pointer,
// saturating occupancy count and checkpoint/restore for mispredict repair.
module ras #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [31:2]      push_pc_i,
    input  logic             pop_i,
    output logic [31:2]      top_o,
    output logic             empty_o,
    output logic [PTR_W-1:0] ckpt_ptr_o,
    output logic [PTR_W:0]   ckpt_cnt_o,
    input  logic             redirect_i,
    input  logic [PTR_W-1:0] redirect_ptr_i,
    input  logic [PTR_W:0]   redirect_cnt_i,
    input  logic             redirect_call_i,
    input  logic [31:2]      redirect_pc_i
);

    localparam logic [PTR_W:0] CntFull = DEPTH[PTR_W:0];

    logic [29:0]      entry_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [29:0]      wr_data;
    logic [PTR_W:0]   rcnt;

    always_comb begin
        tos_d   = tos_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_ptr  = tos_q;
        wr_data = push_pc_i + 30'd1;
        rcnt    = (redirect_cnt_i > CntFull) ? CntFull : redirect_cnt_i;

        if (redirect_i) begin
            tos_d = redirect_ptr_i;
            cnt_d = rcnt;
            if (redirect_call_i) begin
                wr_en   = 1'b1;
                wr_ptr  = redirect_ptr_i + 1'b1;
                wr_data = redirect_pc_i + 30'd1;
                tos_d   = wr_ptr;
                cnt_d   = (rcnt == CntFull) ? CntFull : rcnt + 1'b1;
            end
        end else if (push_i && pop_i && cnt_q != '0) begin
            // Tail call through a return: replace the top in place.
            wr_en  = 1'b1;
            wr_ptr = tos_q;
        end else if (push_i) begin
            // On a full stack the wrap overwrites the oldest entry.
            wr_en  = 1'b1;
            wr_ptr = tos_q + 1'b1;
            tos_d  = wr_ptr;
            cnt_d  = (cnt_q == CntFull) ? CntFull : cnt_q + 1'b1;
        end else if (pop_i && cnt_q != '0) begin
            tos_d = tos_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tos_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                entry_q[wr_ptr] <= wr_data;
            end
        end
    end

    // Popped entries are left in place so a redirect can re-expose them.
    assign empty_o    = (cnt_q == '0);
    assign top_o      = empty_o ? 30'd0 : entry_q[tos_q];
    assign ckpt_ptr_o = tos_q;
    assign ckpt_cnt_o = cnt_q;

endmodule
